traffic_controller: RTL and testbench
=====================================

// Module: traffic_controller
// PURPOSE
//   Timing/sequencing FSM for a main/side road junction with pedestrian crossing.
//   Sits directly upstream of the lamp decoder and drives its 7-bit 'signal' bus
//   (bit0 RED_MAIN, bit1 YELLOW_MAIN, bit2 GREEN_MAIN, bit3 RED_SIDE, bit4 YELLOW_SIDE,
//   bit5 GREEN_SIDE, bit6 WALK). Main road rests on green; side-road car sensor and
//   walk button requests are latched and served in turn.
// PARAMETERS
//   TW      8   width of phase timer, in ticks
//   T_MAIN  10  minimum MAIN_GREEN duration, ticks (>=1)
//   T_SIDE  6   SIDE_GREEN duration, ticks (>=1)
//   T_YEL   3   each yellow phase duration, ticks (>=1)
//   T_RED   2   each all-red clearance duration, ticks (>=1)
//   T_WALK  5   WALK phase duration, ticks (>=1)
// PORTS
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous, active-low reset
//   tick      in   1  one-cycle timebase enable (e.g. 1 Hz strobe); all timing counts ticks
//   sensor    in   1  side-road car present, level or pulse, sampled every clk
//   walk_btn  in   1  pedestrian request, level or pulse, sampled every clk
//   signal    out  7  registered lamp bus to decoder, encoding above
//   phase     out  3  current state code (debug/verification)
// BEHAVIOUR
//   - States (code): MAIN_GREEN 0, MAIN_YELLOW 1, ALL_RED_A 2, WALK 3, SIDE_GREEN 4,
//     SIDE_YELLOW 5, ALL_RED_B 6. Code 7 unreachable -> next clk to ALL_RED_B.
//   - signal per state: MG 7'h0C, MY 7'h0A, ARA 7'h09, WALK 7'h49, SG 7'h21, SY 7'h11,
//     ARB 7'h09. signal is a registered function of next state: changes with phase.
//   - Reset (async assert, any time incl. mid-phase): phase=ALL_RED_B, signal=7'h09,
//     timer=T_RED-1, side_pend=0, walk_pend=0. Release is synchronous to clk.
//   - Timer: on state entry load (duration-1). On tick: if timer!=0 decrement; if timer==0,
//     take the exit transition. Every timed state thus lasts exactly N ticks.
//   - MAIN_GREEN: after T_MAIN ticks timer holds 0; exit to MAIN_YELLOW only on a tick with
//     timer==0 and (side_pend|walk_pend). Otherwise remains indefinitely.
//   - MY->ARA. ARA->WALK if walk_pend else SIDE_GREEN. WALK->SIDE_GREEN if side_pend else
//     ARB. SG->SY->ARB->MAIN_GREEN.
//   - ARA with walk_pend=0 always has side_pend=1 (entry condition), so SG is served.
//   - Request latches: side_pend set by sensor=1, cleared on cycle of entry to SIDE_GREEN;
//     walk_pend set by walk_btn=1, cleared on entry to WALK. Set and clear same cycle:
//     clear wins (request counts as served). Requests during own phase ignored likewise.
//   - Requests arriving in any other state are held until served; no loss, no double serve.
//   - No tick: FSM and timer frozen; signal stable.
//   - Invariant (assert): never green/yellow on both roads; WALK only with both reds.
// STRUCTURE
//   - Shared package traffic_pkg: 7-bit lamp bit constants (shared with decoder), state
//     codes, per-state signal constants.
//   - One sub-module phase_timer (TW-bit loadable down-counter, tick enable, zero flag).
//   - FSM, request latches and output register in this module.
// TESTING (default parameters)
//   1 Reset: assert rst_n=0 mid SIDE_GREEN -> same-instant signal=7'h09, phase=6; release,
//     2 ticks -> phase=0, signal=7'h0C.
//   2 Idle: no sensor/walk for 50 ticks after MAIN_GREEN entry -> signal stays 7'h0C.
//   3 Side: 1-clk sensor pulse at MG tick 3 -> MG exits on tick 10; then 7'h0A x3,
//     7'h09 x2, 7'h21 x6, 7'h11 x3, 7'h09 x2, back to 7'h0C; side_pend=0.
//   4 Walk only: walk_btn at MG tick 12 (past minimum) -> exit on that tick; 7'h0A x3,
//     7'h09 x2, 7'h49 x5, 7'h09 x2, 7'h0C; no SIDE_GREEN.
//   5 Both + race: sensor and walk in MG -> WALK then SG; walk_btn held on WALK entry
//     cycle -> walk_pend=0 after, no second WALK.
//   6 Tick stall: hold tick=0 for 100 clk mid MY -> phase/signal/timer unchanged.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the junction controller and the downstream lamp decoder:
// lamp bit positions, state codes and the lamp pattern driven in each state.
package traffic_pkg;

    localparam int LAMP_W = 7;

    localparam int RED_MAIN    = 0;
    localparam int YELLOW_MAIN = 1;
    localparam int GREEN_MAIN  = 2;
    localparam int RED_SIDE    = 3;
    localparam int YELLOW_SIDE = 4;
    localparam int GREEN_SIDE  = 5;
    localparam int WALK_LAMP   = 6;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        WALK        = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED_B   = 3'd6
    } state_t;

    localparam logic [LAMP_W-1:0] SIG_MG   = 7'h0C;
    localparam logic [LAMP_W-1:0] SIG_MY   = 7'h0A;
    localparam logic [LAMP_W-1:0] SIG_ARA  = 7'h09;
    localparam logic [LAMP_W-1:0] SIG_WALK = 7'h49;
    localparam logic [LAMP_W-1:0] SIG_SG   = 7'h21;
    localparam logic [LAMP_W-1:0] SIG_SY   = 7'h11;
    localparam logic [LAMP_W-1:0] SIG_ARB  = 7'h09;

    function automatic logic [LAMP_W-1:0] state_signal(input state_t s);
        case (s)
            MAIN_GREEN:  state_signal = SIG_MG;
            MAIN_YELLOW: state_signal = SIG_MY;
            ALL_RED_A:   state_signal = SIG_ARA;
            WALK:        state_signal = SIG_WALK;
            SIDE_GREEN:  state_signal = SIG_SG;
            SIDE_YELLOW: state_signal = SIG_SY;
            default:     state_signal = SIG_ARB;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; decrements only on tick and
// parks at zero. A load always takes priority over counting.
module phase_timer #(
    parameter int              TW      = 8,
    parameter logic [TW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_controller.sv
// Main/side junction sequencer with pedestrian phase. Requests are latched and
// served in turn; lamp bus is registered from the next state so it tracks phase.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int TW     = 8,
    parameter int T_MAIN = 10,
    parameter int T_SIDE = 6,
    parameter int T_YEL  = 3,
    parameter int T_RED  = 2,
    parameter int T_WALK = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              sensor,
    input  logic              walk_btn,
    output logic [LAMP_W-1:0] signal,
    output logic [2:0]        phase
);

    state_t        state_q, state_d;
    logic          side_pend, walk_pend;
    logic          timer_zero, timer_load;
    logic          expire;
    logic [TW-1:0] load_val;

    function automatic logic [TW-1:0] dur_minus1(input state_t s);
        case (s)
            MAIN_GREEN:  dur_minus1 = TW'(T_MAIN - 1);
            MAIN_YELLOW,
            SIDE_YELLOW: dur_minus1 = TW'(T_YEL - 1);
            WALK:        dur_minus1 = TW'(T_WALK - 1);
            SIDE_GREEN:  dur_minus1 = TW'(T_SIDE - 1);
            default:     dur_minus1 = TW'(T_RED - 1);
        endcase
    endfunction

    phase_timer #(
        .TW      (TW),
        .RST_VAL (TW'(T_RED - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .load     (timer_load),
        .load_val (load_val),
        .zero     (timer_zero)
    );

    assign expire = tick && timer_zero;

    // No state transitions to itself, so any change of state is a phase entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (expire && (side_pend || walk_pend)) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expire) state_d = ALL_RED_A;
            ALL_RED_A:   if (expire) state_d = walk_pend ? WALK : SIDE_GREEN;
            WALK:        if (expire) state_d = side_pend ? SIDE_GREEN : ALL_RED_B;
            SIDE_GREEN:  if (expire) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (expire) state_d = ALL_RED_B;
            ALL_RED_B:   if (expire) state_d = MAIN_GREEN;
            default:     state_d = ALL_RED_B;
        endcase
        timer_load = (state_d != state_q);
        load_val   = dur_minus1(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ALL_RED_B;
            signal    <= SIG_ARB;
            side_pend <= 1'b0;
            walk_pend <= 1'b0;
        end else begin
            state_q   <= state_d;
            signal    <= state_signal(state_d);
            // Clearing whenever the next state is the serving phase covers both the
            // entry cycle race and requests made during the phase itself.
            side_pend <= (state_d == SIDE_GREEN) ? 1'b0 : (side_pend | sensor);
            walk_pend <= (state_d == WALK)       ? 1'b0 : (walk_pend | walk_btn);
        end
    end

    assign phase = state_q;

    a_lamp_safe: assert property (@(posedge clk) disable iff (!rst_n)
        !((signal[GREEN_MAIN] || signal[YELLOW_MAIN]) &&
          (signal[GREEN_SIDE] || signal[YELLOW_SIDE])) &&
        (!signal[WALK_LAMP] || (signal[RED_MAIN] && signal[RED_SIDE])));

endmodule

// File: tb/tb_traffic_controller.sv
// Directed bench for traffic_controller at default parameters: reset, side and walk
// service sequences, idle rest, request races and tick stall.
module tb_traffic_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       sensor = 1'b0;
    logic       walk_btn = 1'b0;
    logic [6:0] signal;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;

    logic [6:0] exp_q[$];

    traffic_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sensor   (sensor),
        .walk_btn (walk_btn),
        .signal   (signal),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // One tick pulse spanning one rising edge; returns at the following falling edge.
    task automatic do_tick(input logic w);
        @(negedge clk);
        tick     = 1'b1;
        walk_btn = w;
        @(negedge clk);
        tick     = 1'b0;
        walk_btn = 1'b0;
    endtask

    task automatic pulse_req(input logic s, input logic w);
        @(negedge clk);
        sensor   = s;
        walk_btn = w;
        @(negedge clk);
        sensor   = 1'b0;
        walk_btn = 1'b0;
    endtask

    task automatic push_n(input logic [6:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (signal !== 7'h09 || phase !== 3'd6) begin
            fails++;
            $display("FAIL reset_state: signal=%h phase=%0d, want 09/6", signal, phase);
        end
        rst_n = 1'b1;
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h09 || phase !== 3'd6) begin
            fails++;
            $display("FAIL reset_tick1: signal=%h phase=%0d, want 09/6", signal, phase);
        end
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h0C || phase !== 3'd0) begin
            fails++;
            $display("FAIL reset_tick2: signal=%h phase=%0d, want 0C/0", signal, phase);
        end
    endtask

    // Fresh MAIN_GREEN; sensor pulse before tick 3, exit on tick 10, full side cycle.
    task automatic test_side;
        int k;
        exp_q.delete();
        push_n(7'h0C, 2);
        for (int i = 0; i < 2; i++) begin
            do_tick(1'b0);
            tests++;
            if (signal !== exp_q.pop_front()) begin
                fails++;
                $display("FAIL side_pre tick%0d: signal=%h want 0C", i + 1, signal);
            end
        end
        pulse_req(1'b1, 1'b0);
        push_n(7'h0C, 7);
        push_n(7'h0A, 3);
        push_n(7'h09, 2);
        push_n(7'h21, 6);
        push_n(7'h11, 3);
        push_n(7'h09, 2);
        push_n(7'h0C, 11);
        k = 3;
        while (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            do_tick(1'b0);
            tests++;
            if (signal !== e) begin
                fails++;
                $display("FAIL side_seq tick%0d: signal=%h want %h", k, signal, e);
            end
            k++;
        end
    endtask

    // MAIN_GREEN already past its minimum: walk request leaves on the very next tick.
    task automatic test_walk;
        int k;
        pulse_req(1'b0, 1'b1);
        exp_q.delete();
        push_n(7'h0A, 3);
        push_n(7'h09, 2);
        push_n(7'h49, 5);
        push_n(7'h09, 2);
        push_n(7'h0C, 1);
        k = 0;
        while (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            do_tick(1'b0);
            tests++;
            if (signal !== e) begin
                fails++;
                $display("FAIL walk_seq step%0d: signal=%h want %h", k, signal, e);
            end
            if (k == 5) begin
                tests++;
                if (phase !== 3'd3) begin
                    fails++;
                    $display("FAIL walk_phase: phase=%0d want 3", phase);
                end
            end
            k++;
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 50; i++) begin
            do_tick(1'b0);
            tests++;
            if (signal !== 7'h0C || phase !== 3'd0) begin
                fails++;
                $display("FAIL idle tick%0d: signal=%h phase=%0d want 0C/0", i + 1, signal, phase);
            end
        end
    endtask

    // Both requests: WALK first then SIDE_GREEN; walk_btn held on WALK entry is absorbed.
    task automatic test_both;
        int k;
        pulse_req(1'b1, 1'b1);
        exp_q.delete();
        push_n(7'h0A, 3);
        push_n(7'h09, 2);
        push_n(7'h49, 5);
        push_n(7'h21, 6);
        push_n(7'h11, 3);
        push_n(7'h09, 2);
        push_n(7'h0C, 11);
        k = 0;
        while (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            do_tick(k == 5);
            tests++;
            if (signal !== e) begin
                fails++;
                $display("FAIL both_seq step%0d: signal=%h want %h", k, signal, e);
            end
            if (k == 10) begin
                tests++;
                if (phase !== 3'd4) begin
                    fails++;
                    $display("FAIL both_phase_sg: phase=%0d want 4", phase);
                end
            end
            k++;
        end
    endtask

    // Stall mid MAIN_YELLOW, then confirm the remaining duration is unchanged.
    task automatic test_stall;
        int bad;
        pulse_req(1'b1, 1'b0);
        do_tick(1'b0);
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h0A || phase !== 3'd1) begin
            fails++;
            $display("FAIL stall_entry: signal=%h phase=%0d want 0A/1", signal, phase);
        end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (signal !== 7'h0A || phase !== 3'd1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d cycles changed, want 0", bad);
        end
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h0A || phase !== 3'd1) begin
            fails++;
            $display("FAIL stall_resume1: signal=%h phase=%0d want 0A/1", signal, phase);
        end
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h09 || phase !== 3'd2) begin
            fails++;
            $display("FAIL stall_resume2: signal=%h phase=%0d want 09/2", signal, phase);
        end
        do_tick(1'b0);
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h21 || phase !== 3'd4) begin
            fails++;
            $display("FAIL stall_to_sg: signal=%h phase=%0d want 21/4", signal, phase);
        end
    endtask

    task automatic test_reset_mid;
        do_tick(1'b0);
        do_tick(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (signal !== 7'h09 || phase !== 3'd6) begin
            fails++;
            $display("FAIL reset_mid_async: signal=%h phase=%0d want 09/6", signal, phase);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h09 || phase !== 3'd6) begin
            fails++;
            $display("FAIL reset_mid_tick1: signal=%h phase=%0d want 09/6", signal, phase);
        end
        do_tick(1'b0);
        tests++;
        if (signal !== 7'h0C || phase !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_tick2: signal=%h phase=%0d want 0C/0", signal, phase);
        end
    endtask

    initial begin
        test_reset();
        test_side();
        test_walk();
        test_idle();
        test_both();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
